// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the writeback port arbiter.
package wb_arb_pkg;

    localparam int unsigned REG_W            = 5;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned DEPTH_DEF        = 2;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // One buffered MDU result: destination register and its value.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_res_fifo.sv
// Small synchronous FIFO holding MDU results until the write port is free.
module wb_res_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority,
// buffered MDU results drain in free cycles, starvation raises a stall.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wb_regwrite_i,
    input  logic [REG_W-1:0]         wb_rd_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     mdu_valid_i,
    input  logic [REG_W-1:0]         mdu_rd_i,
    input  logic [DATA_W-1:0]        mdu_data_i,
    output logic                     mdu_ready_o,
    output logic                     rf_we_o,
    output logic [REG_W-1:0]         rf_addr_o,
    output logic [DATA_W-1:0]        rf_data_o,
    output logic                     stall_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    wb_entry_t  push_entry;
    wb_entry_t  head;
    logic       full;
    logic       empty;
    logic       pop;
    logic       pipe_live;
    logic       starve_hit;
    logic [3:0] starve_cnt;

    assign pipe_live        = wb_regwrite_i && (wb_rd_i != '0);
    assign push_entry.rd    = mdu_rd_i;
    assign push_entry.data  = mdu_data_i;
    assign mdu_ready_o      = !full;

    wb_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .push       (mdu_valid_i),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (fifo_count_o)
    );

    // Port grant: pipeline first, then FIFO head; rd=0 heads are popped silently.
    always_comb begin
        rf_we_o   = 1'b0;
        rf_addr_o = '0;
        rf_data_o = '0;
        pop       = 1'b0;
        if (rst_i) begin
            if (pipe_live) begin
                rf_we_o   = 1'b1;
                rf_addr_o = wb_rd_i;
                rf_data_o = wb_data_i;
            end else if (!empty) begin
                rf_we_o   = (head.rd != '0);
                rf_addr_o = head.rd;
                rf_data_o = head.data;
                pop       = 1'b1;
            end
        end
    end

    // The counter steps to STARVE_LIMIT on this edge.
    assign starve_hit = !empty && pipe_live && (starve_cnt == LIMIT_M1);

    // Starvation counter: counts consecutive cycles the head is denied.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (pipe_live && (starve_cnt != 4'hF)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Stall request: raised when starvation hits the limit, dropped on the next pop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_o <= 1'b0;
        end else if (pop) begin
            stall_o <= 1'b0;
        end else if (starve_hit) begin
            stall_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_i;
    logic        wb_regwrite_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [31:0] mdu_data_i;
    logic        mdu_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        stall_o;
    logic [1:0]  fifo_count_o;

    int unsigned n_checks;
    int unsigned n_fail;

    wb_port_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .wb_regwrite_i (wb_regwrite_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .mdu_valid_i   (mdu_valid_i),
        .mdu_rd_i      (mdu_rd_i),
        .mdu_data_i    (mdu_data_i),
        .mdu_ready_o   (mdu_ready_o),
        .rf_we_o       (rf_we_o),
        .rf_addr_o     (rf_addr_o),
        .rf_data_o     (rf_data_o),
        .stall_o       (stall_o),
        .fifo_count_o  (fifo_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_regwrite_i = we;
        wb_rd_i       = rd;
        wb_data_i     = d;
    endtask

    task automatic mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mdu_valid_i = v;
        mdu_rd_i    = rd;
        mdu_data_i  = d;
    endtask

    task automatic port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".we"},   32'(rf_we_o),   32'(we));
        check({tag, ".addr"}, 32'(rf_addr_o), 32'(a));
        check({tag, ".data"}, rf_data_o,      d);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_i    = 1'b0;
        pipe(1'b1, 5'd3, 32'h1234_5678);
        mdu(1'b0, 5'd0, 32'h0);

        // Reset holds the port off even with a live pipeline request
        repeat (2) @(posedge clk);
        @(negedge clk);
        port("rst", 1'b0, 5'd0, 32'h0);
        check("rst.ready", 32'(mdu_ready_o), 32'd1);
        check("rst.stall", 32'(stall_o), 32'd0);
        check("rst.count", 32'(fifo_count_o), 32'd0);
        rst_i = 1'b1;
        pipe(1'b0, 5'd0, 32'h0);
        tick();

        // Idle port: result must pass through FIFO, then write next cycle
        mdu(1'b1, 5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        port("idle.c0", 1'b0, 5'd0, 32'h0);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("idle.count1", 32'(fifo_count_o), 32'd1);
        port("idle.c1", 1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        check("idle.count0", 32'(fifo_count_o), 32'd0);
        port("idle.c2", 1'b0, 5'd0, 32'h0);
        tick();

        // Priority: pipeline writes win; rd=7 goes out once wb_rd_i=0
        mdu(1'b1, 5'd7, 32'h77);
        pipe(1'b1, 5'd3, 32'h11);
        @(negedge clk);
        port("prio.c0", 1'b1, 5'd3, 32'h11);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        pipe(1'b1, 5'd4, 32'h22);
        @(negedge clk);
        port("prio.c1", 1'b1, 5'd4, 32'h22);
        check("prio.count", 32'(fifo_count_o), 32'd1);
        tick();
        pipe(1'b1, 5'd0, 32'h33);
        @(negedge clk);
        port("prio.c2", 1'b1, 5'd7, 32'h77);
        tick();
        @(negedge clk);
        check("prio.drained", 32'(fifo_count_o), 32'd0);
        tick();

        // Full: two pushes under a pipeline stream, third is held off
        pipe(1'b1, 5'd1, 32'hAA);
        mdu(1'b1, 5'd10, 32'hA);
        tick();
        mdu(1'b1, 5'd11, 32'hB);
        tick();
        mdu(1'b1, 5'd12, 32'hC);
        @(negedge clk);
        check("full.ready", 32'(mdu_ready_o), 32'd0);
        check("full.count", 32'(fifo_count_o), 32'd2);
        tick();
        @(negedge clk);
        check("full.held", 32'(fifo_count_o), 32'd2);
        tick();
        pipe(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        port("full.pop10", 1'b1, 5'd10, 32'hA);
        check("full.ready2", 32'(mdu_ready_o), 32'd0);
        tick();
        @(negedge clk);
        check("full.count1", 32'(fifo_count_o), 32'd1);
        check("full.ready3", 32'(mdu_ready_o), 32'd1);
        port("full.pop11", 1'b1, 5'd11, 32'hB);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("full.pushpop", 32'(fifo_count_o), 32'd1);
        port("full.pop12", 1'b1, 5'd12, 32'hC);
        tick();
        @(negedge clk);
        check("full.empty", 32'(fifo_count_o), 32'd0);
        check("full.nostall", 32'(stall_o), 32'd0);
        tick();

        // Starvation: head denied 4 cycles raises stall; bubble pops and clears it
        pipe(1'b1, 5'd2, 32'h200);
        mdu(1'b1, 5'd20, 32'h14);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("starve.pre%0d", i), 32'(stall_o), 32'd0);
            tick();
        end
        @(negedge clk);
        check("starve.up", 32'(stall_o), 32'd1);
        tick();
        pipe(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        port("starve.bubble", 1'b1, 5'd20, 32'h14);
        check("starve.held", 32'(stall_o), 32'd1);
        tick();
        @(negedge clk);
        check("starve.down", 32'(stall_o), 32'd0);
        check("starve.count", 32'(fifo_count_o), 32'd0);
        tick();

        // rd=0 entry drops silently, following rd=9 written next free cycle
        pipe(1'b1, 5'd6, 32'h66);
        mdu(1'b1, 5'd0, 32'h55);
        tick();
        mdu(1'b1, 5'd9, 32'h99);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        pipe(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("rd0.count", 32'(fifo_count_o), 32'd2);
        check("rd0.we", 32'(rf_we_o), 32'd0);
        tick();
        @(negedge clk);
        check("rd0.count1", 32'(fifo_count_o), 32'd1);
        port("rd0.next", 1'b1, 5'd9, 32'h99);
        tick();
        @(negedge clk);
        check("rd0.count0", 32'(fifo_count_o), 32'd0);
        tick();

        // Asynchronous reset mid-operation discards buffered results
        pipe(1'b1, 5'd8, 32'h88);
        mdu(1'b1, 5'd13, 32'hD);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        #2;
        check("arst.pre", 32'(fifo_count_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("arst.count", 32'(fifo_count_o), 32'd0);
        port("arst", 1'b0, 5'd0, 32'h0);
        check("arst.ready", 32'(mdu_ready_o), 32'd1);
        @(negedge clk);
        rst_i = 1'b1;
        pipe(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        port("arst.after", 1'b0, 5'd0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
